// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Start/busy/done handshake; result and flags registered and held between completions.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_work;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_a_i;
    logic             w_b_i;
    logic             w_d;
    logic             w_brw_next;
    logic [WIDTH-1:0] w_work_next;

    // DONE behaves like IDLE for acceptance, which gives back-to-back operation.
    assign w_accept    = start && (r_state != S_RUN);
    assign w_last      = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_a_i       = r_a_sh[0];
    assign w_b_i       = r_b_sh[0];
    assign w_d         = w_a_i ^ w_b_i ^ r_brw;
    assign w_brw_next  = (~w_a_i & w_b_i) | (~(w_a_i ^ w_b_i) & r_brw);
    assign w_work_next = {w_d, r_work[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_work  <= '0;
            r_brw   <= bin;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_work <= w_work_next;
            r_brw  <= w_brw_next;
            r_cnt  <= r_cnt + CW'(1);
            // Operand MSBs were captured at accept since the shift regs no longer hold them.
            if (w_last) begin
                r_diff <= w_work_next;
                r_bout <= w_brw_next;
                r_ovf  <= (r_a_msb ^ r_b_msb) & (w_work_next[WIDTH-1] ^ r_a_msb);
                r_zero <= ~|w_work_next;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor: diff = a - b - bin, resolved LSB-first, one bit per clock, through a single registered borrow stage. It is the inverse-direction companion to the ripple adders in the arithmetic lab set. It trades latency for area and gives block-level users a start/busy/done handshake. Intended as the subtract unit for iterative datapaths (compare, restoring divide).

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse; results updated in the same cycle
diff  output  WIDTH  registered difference, held until next completion
bout  output  1  registered final borrow-out (unsigned underflow)
ovf  output  1  registered signed (two's-complement) overflow
zero  output  1  registered flag, 1 when diff == 0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, diff, bout, ovf and zero all 0; internal shift registers, borrow flop and counter cleared.
- States:
  - IDLE: on rising edge with start=1, capture a, b and bin into internal regs (borrow flop = bin, bit counter = 0) and go to RUN.
  - RUN: each edge processes bit i = counter, taken from the LSB of the operand shift regs.
    - d = a_i ^ b_i ^ brw
    - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw)
    - d shifts into the MSB of the working result reg; operand regs shift right.
    - On the edge that processes bit WIDTH-1, load diff/bout/ovf/zero from the completed working values, assert done, and go to DONE.
  - DONE: lasts exactly 1 cycle. done=1, busy=0. Next edge behaves as IDLE, so start=1 here is accepted (back-to-back operation). Otherwise return to IDLE with done=0.
- Timing and outputs:
  - busy=1 exactly in RUN: from the accept edge until the completion edge. Latency from the accept edge to the done-rise edge is WIDTH cycles.
  - start while busy=1 is ignored: not queued, no effect on a run in progress.
  - a, b and bin are don't-care after the accept edge.
  - diff, bout, ovf and zero change only on completion edges. During RUN they hold the previous result; the working register is separate.
- Flags:
  - ovf = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]), using captured operands and final diff.
  - bout = 1 iff the unsigned value a < b + bin.
  - zero = ~|diff.
  - Flags are evaluated on the full WIDTH-bit result including bin.
- Reset mid-operation aborts immediately: no done pulse, and outputs return to reset values.
- A start asserted on the same edge that rst_n releases is not guaranteed to be accepted; the bench holds start=0 for one cycle after reset.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0 -> done pulses exactly 4 cycles after the accept edge, for 1 cycle; diff=6, bout=0, ovf=0, zero=0; busy high for exactly 4 cycles.
- a=3, b=9, bin=0 -> diff=0xA, bout=1, ovf=1 (3 - (-7) = 10 exceeds signed range).
- Two cases in one run: a=5, b=5, bin=0 -> diff=0, zero=1, bout=0; then a=0, b=0, bin=1 -> diff=0xF, bout=1, ovf=0, zero=0.
- a=8, b=1, bin=0 -> diff=7, ovf=1, bout=0; start pulsed again mid-RUN with other operands -> ignored; result and latency unchanged.
- Back-to-back: start=1 in the DONE cycle with a=2, b=1 -> second done exactly 4 cycles later with diff=1; first result held on outputs until then.
- rst_n pulsed low 2 cycles into a run -> busy, done and all outputs 0 immediately; no done pulse follows; a fresh start afterwards completes correctly.
